bram_seq_tester: RTL and testbench

//   Drives both ports of the simple dual-port block RAM (port A write, port B read):
//   on a start pulse, writes a deterministic pattern to every address via port A,

---
 rtl/bram_seq_tester.sv | 168 ++++++++++++++++
 tb/tb_bram_seq_tester.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_seq_tester.sv
// rtl/bram_seq_tester.sv - write/readback pattern tester for a simple dual-port block RAM
module bram_seq_tester #(
    parameter int                ADDR_W   = 9,
    parameter int                DATA_W   = 16,
    parameter int                RD_LAT   = 1,
    parameter logic [DATA_W-1:0] PAT_BASE = 16'hA500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] doutb,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int                CW         = (RD_LAT <= 1) ? 1 : $clog2(RD_LAT);
    localparam logic [CW-1:0]     DRAIN_LAST = CW'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;
    localparam logic [ADDR_W:0]   CNT_ONE    = 1;
    localparam int                PW         = ADDR_W + 1;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_inc;
    logic [CW-1:0]     drain_cnt;

    // Compare pipe: each stage is {valid, addr}; stage 0 in the LSBs, oldest on top.
    logic [RD_LAT*PW-1:0] pipe;
    logic [RD_LAT*PW-1:0] pipe_next;
    logic                 cmp_valid;
    logic [ADDR_W-1:0]    cmp_addr;
    logic                 mismatch;
    logic                 accept;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] ext;
        ext = DATA_W'(a);
        return ext + PAT_BASE;
    endfunction

    assign addr_inc = addr + ADDR_W'(1);
    assign accept   = (state == S_IDLE) && start;

    generate
        if (RD_LAT == 1) begin : g_pipe_one
            assign pipe_next = {enb, addrb};
        end else begin : g_pipe_multi
            assign pipe_next = {pipe[(RD_LAT-1)*PW-1:0], enb, addrb};
        end
    endgenerate

    assign cmp_valid = pipe[RD_LAT*PW-1];
    assign cmp_addr  = pipe[RD_LAT*PW-2 -: ADDR_W];
    assign mismatch  = cmp_valid && (doutb != pattern(cmp_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            addr      <= '0;
            drain_cnt <= '0;
            wea       <= 1'b0;
            addra     <= '0;
            dina      <= '0;
            enb       <= 1'b0;
            addrb     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_WRITE;
                        addr  <= '0;
                        wea   <= 1'b1;
                        addra <= '0;
                        dina  <= pattern('0);
                        busy  <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (addr == ADDR_LAST) begin
                        state <= S_READ;
                        addr  <= '0;
                        wea   <= 1'b0;
                        addra <= '0;
                        dina  <= '0;
                        enb   <= 1'b1;
                        addrb <= '0;
                    end else begin
                        addr  <= addr_inc;
                        addra <= addr_inc;
                        dina  <= pattern(addr_inc);
                    end
                end
                S_READ: begin
                    if (addr == ADDR_LAST) begin
                        state     <= S_DRAIN;
                        addr      <= '0;
                        enb       <= 1'b0;
                        addrb     <= '0;
                        drain_cnt <= '0;
                    end else begin
                        addr  <= addr_inc;
                        addrb <= addr_inc;
                    end
                end
                S_DRAIN: begin
                    // The final compare lands on the same edge that raises done.
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe <= pipe_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err            <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else if (accept) begin
            err            <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else if (mismatch) begin
            err     <= 1'b1;
            err_cnt <= err_cnt + CNT_ONE;
            if (err_cnt == '0) begin
                first_err_addr <= cmp_addr;
            end
        end
    end

endmodule

// File: tb/tb_bram_seq_tester.sv
// tb/tb_bram_seq_tester.sv - randomized self-checking bench for bram_seq_tester
module tb_bram_seq_tester;

    localparam int             AW   = 9;
    localparam int             DW   = 16;
    localparam int             N    = 512;
    localparam logic [DW-1:0]  BASE = 16'hA500;

    logic clk = 1'b0;
    logic rst;
    logic start1, start3;
    logic sel;

    logic          wea1, enb1, busy1, done1, err1;
    logic [AW-1:0] addra1, addrb1, fea1;
    logic [DW-1:0] dina1, doutb1;
    logic [AW:0]   cnt1;

    logic          wea3, enb3, busy3, done3, err3;
    logic [AW-1:0] addra3, addrb3, fea3;
    logic [DW-1:0] dina3, doutb3;
    logic [AW:0]   cnt3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bram_seq_tester #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .PAT_BASE(BASE)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .wea(wea1), .addra(addra1), .dina(dina1),
        .enb(enb1), .addrb(addrb1), .doutb(doutb1),
        .busy(busy1), .done(done1), .err(err1), .err_cnt(cnt1), .first_err_addr(fea1)
    );

    bram_seq_tester #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .PAT_BASE(BASE)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .wea(wea3), .addra(addra3), .dina(dina3),
        .enb(enb3), .addrb(addrb3), .doutb(doutb3),
        .busy(busy3), .done(done3), .err(err3), .err_cnt(cnt3), .first_err_addr(fea3)
    );

    // RAM models: plain storage, a read-latency pipe, and optional read-side corruption.
    logic [DW-1:0] mem1 [N];
    logic [DW-1:0] mem3 [N];
    logic          bad  [N];
    logic          zero_mode;
    logic [DW-1:0] rq1;
    logic [DW-1:0] rq3 [3];

    function automatic logic [DW-1:0] pat(input int a);
        return BASE + DW'(a);
    endfunction

    function automatic logic [DW-1:0] ram_out(input logic [DW-1:0] stored, input logic [AW-1:0] a);
        if (zero_mode) return '0;
        return stored ^ DW'(bad[a]);
    endfunction

    always @(posedge clk) begin
        if (wea1) mem1[addra1] <= dina1;
        if (wea3) mem3[addra3] <= dina3;
        if (enb1) rq1 <= ram_out(mem1[addrb1], addrb1);
        if (enb3) rq3[0] <= ram_out(mem3[addrb3], addrb3);
        rq3[1] <= rq3[0];
        rq3[2] <= rq3[1];
    end

    assign doutb1 = rq1;
    assign doutb3 = rq3[2];

    logic          o_wea, o_enb, o_busy, o_done, o_err;
    logic [AW-1:0] o_addra, o_addrb, o_fea;
    logic [DW-1:0] o_dina;
    logic [AW:0]   o_cnt;

    assign o_wea   = sel ? wea3   : wea1;
    assign o_enb   = sel ? enb3   : enb1;
    assign o_busy  = sel ? busy3  : busy1;
    assign o_done  = sel ? done3  : done1;
    assign o_err   = sel ? err3   : err1;
    assign o_addra = sel ? addra3 : addra1;
    assign o_addrb = sel ? addrb3 : addrb1;
    assign o_fea   = sel ? fea3   : fea1;
    assign o_dina  = sel ? dina3  : dina1;
    assign o_cnt   = sel ? cnt3   : cnt1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start3 = v;
        else     start1 = v;
    endtask

    task automatic run_test(input string nm, input logic s3, input bit inject);
        int lat, n_wr, wr_first, wr_last, bad_wr, n_rd, bad_rd, n_done, done_cyc, busy_bad;
        int e_cnt, e_first, last_c;
        logic [DW-1:0] d3;
        logic [DW-1:0] r;
        sel = s3;
        lat = s3 ? 3 : 1;
        n_wr = 0; wr_first = 0; wr_last = 0; bad_wr = 0; n_rd = 0; bad_rd = 0;
        n_done = 0; done_cyc = 0; busy_bad = 0; d3 = '0;
        last_c = 2 * N + lat + 4;
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        for (int c = 1; c <= last_c; c++) begin
            if (o_wea) begin
                n_wr++;
                if (wr_first == 0) wr_first = c;
                wr_last = c;
                if (o_addra != AW'(c - 1) || o_dina != pat(c - 1)) bad_wr++;
                if (o_addra == AW'(3)) d3 = o_dina;
            end
            if (o_enb) begin
                n_rd++;
                if (o_addrb != AW'(c - N - 1)) bad_rd++;
            end
            if (o_done) begin
                n_done++;
                done_cyc = c;
            end
            if ((c <= 2 * N + lat + 1) != o_busy) busy_bad++;
            set_start(inject && (c == 10 || c == 600 || c == 2 * N + lat + 1));
            @(posedge clk); #1;
        end
        set_start(1'b0);
        e_cnt = 0;
        e_first = 0;
        for (int a = 0; a < N; a++) begin
            r = zero_mode ? '0 : (pat(a) ^ DW'(bad[AW'(a)]));
            if (r != pat(a)) begin
                if (e_cnt == 0) e_first = a;
                e_cnt++;
            end
        end
        check_eq({nm, ".wr_count"}, n_wr, N);
        check_eq({nm, ".wr_first"}, wr_first, 1);
        check_eq({nm, ".wr_last"}, wr_last, N);
        check_eq({nm, ".wr_seq_errs"}, bad_wr, 0);
        check_eq({nm, ".dina3"}, d3, 16'hA503);
        check_eq({nm, ".rd_count"}, n_rd, N);
        check_eq({nm, ".rd_seq_errs"}, bad_rd, 0);
        check_eq({nm, ".done_pulses"}, n_done, 1);
        check_eq({nm, ".done_cycle"}, done_cyc, 2 * N + lat + 1);
        check_eq({nm, ".busy_errs"}, busy_bad, 0);
        check_eq({nm, ".err"}, o_err, (e_cnt != 0));
        check_eq({nm, ".err_cnt"}, o_cnt, e_cnt);
        check_eq({nm, ".first_err_addr"}, o_fea, e_first);
    endtask

    task automatic abort_test();
        int n_done, n_busy;
        sel = 1'b0;
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        for (int c = 1; c < 700; c++) begin
            @(posedge clk); #1;
        end
        check_eq("abort.in_read", {o_enb, o_wea}, 2'b10);
        rst = 1'b1;
        #1;
        check_eq("abort.ctl_zero", {o_wea, o_enb, o_busy, o_done, o_err}, 0);
        check_eq("abort.addr_zero", {o_addra, o_addrb}, 0);
        check_eq("abort.res_zero", {o_cnt, o_fea}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        n_done = 0;
        n_busy = 0;
        for (int c = 0; c < N + 10; c++) begin
            @(posedge clk); #1;
            if (o_done) n_done++;
            if (o_busy) n_busy++;
        end
        check_eq("abort.no_done", n_done, 0);
        check_eq("abort.stays_idle", n_busy, 0);
    endtask

    task automatic clear_bad();
        bad = '{default: 1'b0};
    endtask

    initial begin
        rst = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        sel = 1'b0;
        zero_mode = 1'b0;
        clear_bad();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset.ctl1", {wea1, enb1, busy1, done1, err1}, 0);
        check_eq("reset.addr1", {addra1, addrb1}, 0);
        check_eq("reset.res1", {cnt1, fea1, dina1}, 0);
        check_eq("reset.ctl3", {wea3, enb3, busy3, done3, err3}, 0);
        check_eq("reset.addr3", {addra3, addrb3}, 0);
        check_eq("reset.res3", {cnt3, fea3, dina3}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_test("clean", 1'b0, 1'b0);

        bad[5] = 1'b1;
        run_test("bad5", 1'b0, 1'b0);

        clear_bad();
        bad[7] = 1'b1;
        bad[300] = 1'b1;
        bad[511] = 1'b1;
        run_test("bad3", 1'b0, 1'b0);
        clear_bad();
        run_test("reclean", 1'b0, 1'b0);

        run_test("start_ignored", 1'b0, 1'b1);

        abort_test();
        run_test("after_abort", 1'b0, 1'b0);

        run_test("lat3_clean", 1'b1, 1'b0);
        zero_mode = 1'b1;
        run_test("lat3_zero", 1'b1, 1'b0);
        zero_mode = 1'b0;

        for (int r = 0; r < 4; r++) begin
            clear_bad();
            repeat ($urandom_range(1, 12)) bad[AW'($urandom_range(0, N - 1))] = 1'b1;
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            run_test($sformatf("rand%0d", r), logic'(r % 2), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
